// File: rtl/alu_pkg.sv
// Shared ALU definitions: slice width, sequencer states and op encoding.
package alu_pkg;

    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/bk_multiword_addsub.sv
// Byte-serial add/subtract sequencer driving an external 8-bit adder slice.
// One byte per cycle, LSB first; carry is chained through r_carry.
module bk_multiword_addsub
    import alu_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     op_sub,
    input  logic [SLICE_W*WORDS-1:0] opa,
    input  logic [SLICE_W*WORDS-1:0] opb,
    output logic                     busy,
    output logic                     done,
    output logic [SLICE_W*WORDS-1:0] result,
    output logic                     carry_out,
    output logic                     overflow,
    output logic [SLICE_W-1:0]       add_a,
    output logic [SLICE_W-1:0]       add_b,
    output logic                     add_cin,
    input  logic [SLICE_W-1:0]       add_sum,
    input  logic                     add_cout
);

    localparam int W     = SLICE_W * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_result;
    logic             r_cout;
    logic             r_ovf;
    logic             w_accept;
    logic             w_last;

    assign w_accept = start && (r_state == IDLE || r_state == DONE);
    assign w_last   = (r_idx == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        // B is inverted once here; cin=1 completes the negation
                        r_a      <= opa;
                        r_b      <= (op_sub == OP_SUB) ? ~opb : opb;
                        r_carry  <= op_sub;
                        r_idx    <= '0;
                        r_result <= '0;
                        r_state  <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_result[r_idx*SLICE_W +: SLICE_W] <= add_sum;
                    r_carry <= add_cout;
                    if (w_last) begin
                        r_state <= DONE;
                        r_cout  <= add_cout;
                        r_ovf   <= (r_a[W-1] == r_b[W-1]) &&
                                   (add_sum[SLICE_W-1] != r_a[W-1]);
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (r_state == RUN) begin
            add_a   = r_a[r_idx*SLICE_W +: SLICE_W];
            add_b   = r_b[r_idx*SLICE_W +: SLICE_W];
            add_cin = r_carry;
        end
    end

    assign busy      = (r_state == RUN);
    assign done      = (r_state == DONE);
    assign result    = r_result;
    assign carry_out = r_cout;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_bk_multiword_addsub.sv
// Directed bench for bk_multiword_addsub with a behavioural 8-bit slice.
module tb_bk_multiword_addsub;

    localparam int WORDS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op_sub;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        carry_out;
    logic        overflow;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic        add_cin;
    logic [7:0]  add_sum;
    logic        add_cout;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

    bk_multiword_addsub #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_sub    (op_sub),
        .opa       (opa),
        .opb       (opb),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s got %h want %h", tag, obs, exp);
    endtask

    // Drives start for one cycle; returns at the negedge of cycle 1.
    task automatic go(input logic [31:0] a, input logic [31:0] b,
                      input logic sub);
        @(negedge clk);
        start  = 1'b1;
        op_sub = sub;
        opa    = a;
        opb    = b;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Called in cycle 1; n is the cycle number in which done is seen.
    task automatic wait_done(output int n);
        n = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic op_check(input string tag, input logic [31:0] a,
                            input logic [31:0] b, input logic sub,
                            input logic [7:0] b0, input logic [31:0] res,
                            input logic c, input logic v);
        int n;
        go(a, b, sub);
        chk({tag, "_busy1"}, 32'(busy), 32'd1);
        chk({tag, "_cin1"}, 32'(add_cin), 32'(sub));
        chk({tag, "_b0"}, 32'(add_b), 32'(b0));
        wait_done(n);
        chk({tag, "_lat"}, 32'(n), 32'(WORDS + 1));
        chk({tag, "_res"}, result, res);
        chk({tag, "_c"}, 32'(carry_out), 32'(c));
        chk({tag, "_v"}, 32'(overflow), 32'(v));
    endtask

    initial begin
        int n;
        int dones;
        int dcyc;
        logic [31:0] bytes_seen;
        rst    = 1'b1;
        start  = 1'b0;
        op_sub = 1'b0;
        opa    = '0;
        opb    = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_res", result, 32'd0);
        chk("rst_c", 32'(carry_out), 32'd0);
        chk("rst_v", 32'(overflow), 32'd0);
        chk("rst_adda", 32'(add_a), 32'd0);
        rst = 1'b0;

        // Test 1: byte0 FF+01 -> sum 00 with carry
        go(32'h0000_00FF, 32'h0000_0001, 1'b0);
        chk("t1_cin", 32'(add_cin), 32'd0);
        chk("t1_sum0", 32'(add_sum), 32'h00);
        chk("t1_cout0", 32'(add_cout), 32'd1);
        wait_done(n);
        chk("t1_lat", 32'(n), 32'd5);
        chk("t1_res", result, 32'h0000_0100);
        chk("t1_c", 32'(carry_out), 32'd0);
        chk("t1_v", 32'(overflow), 32'd0);
        @(negedge clk);
        chk("t1_idle", 32'(done), 32'd0);
        chk("t1_hold", result, 32'h0000_0100);

        op_check("t2", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 8'h01,
                 32'h0000_0000, 1'b1, 1'b0);
        op_check("t3", 32'h0000_0005, 32'h0000_0007, 1'b1, 8'hF8,
                 32'hFFFF_FFFE, 1'b0, 1'b0);
        op_check("t4a", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 8'h01,
                 32'h8000_0000, 1'b0, 1'b1);
        op_check("t4b", 32'h8000_0000, 32'h0000_0001, 1'b1, 8'hFE,
                 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Test 5a: start held high through RUN
        @(negedge clk);
        start  = 1'b1;
        op_sub = 1'b0;
        opa    = 32'd3;
        opb    = 32'd4;
        dones  = 0;
        dcyc   = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                dcyc = c;
            end
        end
        chk("t5_dones", 32'(dones), 32'd1);
        chk("t5_dcyc", 32'(dcyc), 32'd5);
        chk("t5_res", result, 32'd7);
        @(negedge clk);
        start = 1'b0;
        chk("t5_rerun", 32'(busy), 32'd1);
        wait_done(n);
        chk("t5_lat2", 32'(n), 32'd5);
        chk("t5_res2", result, 32'd7);

        // Test 5b: reset in cycle 2 of RUN
        go(32'h0101_0101, 32'h0202_0202, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5r_busy", 32'(busy), 32'd0);
        chk("t5r_res", result, 32'd0);
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) dones++;
            @(negedge clk);
        end
        chk("t5r_nodone", 32'(dones), 32'd0);

        op_check("t5c", 32'h1234_5678, 32'h1111_1111, 1'b0, 8'h11,
                 32'h2345_6789, 1'b0, 1'b0);

        // Test 6: back-to-back, second start in DONE cycle
        go(32'h1234_5678, 32'h0000_0000, 1'b0);
        for (int k = 0; k < 4; k++) begin
            bytes_seen[8*k +: 8] = add_a;
            @(negedge clk);
        end
        chk("t6_adda", bytes_seen, 32'h7856_3412 >> 0 == 0 ? 0 :
            {8'h12, 8'h34, 8'h56, 8'h78});
        chk("t6_done1", 32'(done), 32'd1);
        chk("t6_res1", result, 32'h1234_5678);
        start  = 1'b1;
        op_sub = 1'b1;
        opa    = 32'h0000_FFFF;
        opb    = 32'h0000_0001;
        @(negedge clk);
        start = 1'b0;
        chk("t6_busy2", 32'(busy), 32'd1);
        wait_done(n);
        chk("t6_dcyc2", 32'(n + 5), 32'd10);
        chk("t6_res2", result, 32'h0000_FFFE);
        chk("t6_c2", 32'(carry_out), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
